// File: rtl/vga_rd_pkg.sv
// Shared defaults, coordinate payload type and ROI helper for the VGA read-side tracker.
package vga_rd_pkg;

    localparam int unsigned DEF_X_WIDTH     = 11;
    localparam int unsigned DEF_Y_WIDTH     = 11;
    localparam int unsigned DEF_FRAME_WIDTH = 8;
    localparam int unsigned DEF_H_ACTIVE    = 640;
    localparam int unsigned DEF_V_ACTIVE    = 480;

    // Pixel coordinate as handed to the vision pipeline
    typedef struct packed {
        logic [DEF_X_WIDTH-1:0] x;
        logic [DEF_Y_WIDTH-1:0] y;
        logic                   valid;
    } coord_t;

    // Inclusive range test used for region-of-interest membership
    function automatic logic in_range(input int unsigned v, input int unsigned lo,
                                      input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_vs_edge.sv
// VS polarity normaliser and registered rising-edge detector for frame start.
module vga_vs_edge #(
    parameter bit VS_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic vs,
    output logic vs_act_c,
    output logic frame_start_c,
    output logic frame_start
);

    logic vs_d;

    assign vs_act_c      = VS_ACTIVE_LOW ? ~vs : vs;
    assign frame_start_c = vs_act_c & ~vs_d;

    // Delay the active VS level and register the one-cycle frame start pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vs_d        <= vs_act_c;
            frame_start <= frame_start_c;
        end
    end

endmodule

// File: rtl/vga_rd_coord_tracker.sv
// Read-side pixel coordinate tracker: X/Y/frame counters, line/frame pulses, ROI and overflow flags.
module vga_rd_coord_tracker
    import vga_rd_pkg::*;
#(
    parameter int unsigned X_WIDTH       = DEF_X_WIDTH,
    parameter int unsigned Y_WIDTH       = DEF_Y_WIDTH,
    parameter int unsigned FRAME_WIDTH   = DEF_FRAME_WIDTH,
    parameter int unsigned H_ACTIVE      = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE      = DEF_V_ACTIVE,
    parameter bit          VS_ACTIVE_LOW = 1'b1,
    parameter bit          SATURATE      = 1'b1,
    parameter int unsigned ROI_X0        = 0,
    parameter int unsigned ROI_X1        = 639,
    parameter int unsigned ROI_Y0        = 0,
    parameter int unsigned ROI_Y1        = 479
) (
    input  logic                   VGA_CLK,
    input  logic                   RESET,
    input  logic                   VGA_VS,
    input  logic                   READ_Request,
    output logic                   PIX_VALID,
    output logic [X_WIDTH-1:0]     X_Cont,
    output logic [Y_WIDTH-1:0]     Y_Cont,
    output logic [FRAME_WIDTH-1:0] FRAME_Cont,
    output logic                   LINE_END,
    output logic [X_WIDTH:0]       LAST_LINE_LEN,
    output logic                   FRAME_START,
    output logic                   ROI_VALID,
    output logic                   X_OVF,
    output logic                   Y_OVF
);

    localparam logic [X_WIDTH-1:0] X_MAX = X_WIDTH'(H_ACTIVE - 1);
    localparam logic [Y_WIDTH-1:0] Y_MAX = Y_WIDTH'(V_ACTIVE - 1);

    // Active geometry must be representable by the counters
    if (H_ACTIVE > 2 ** X_WIDTH) begin : g_bad_h_active
        $error("H_ACTIVE exceeds X_WIDTH range");
    end
    if (V_ACTIVE > 2 ** Y_WIDTH) begin : g_bad_v_active
        $error("V_ACTIVE exceeds Y_WIDTH range");
    end

    logic vs_act_c;
    logic frame_start_c;

    vga_vs_edge #(
        .VS_ACTIVE_LOW(VS_ACTIVE_LOW)
    ) u_vs_edge (
        .clk          (VGA_CLK),
        .rst          (RESET),
        .vs           (VGA_VS),
        .vs_act_c     (vs_act_c),
        .frame_start_c(frame_start_c),
        .frame_start  (FRAME_START)
    );

    logic                   pix_valid_n;
    logic [X_WIDTH-1:0]     x_n;
    logic [Y_WIDTH-1:0]     y_n;
    logic [FRAME_WIDTH-1:0] frame_n;
    logic                   line_end_n;
    logic [X_WIDTH:0]       last_len_n;
    logic                   roi_n;
    logic                   x_ovf_n;
    logic                   y_ovf_n;

    // Next-state: VS wins, else advance X per pixel and Y per completed line
    always_comb begin
        pix_valid_n = 1'b0;
        x_n         = X_Cont;
        y_n         = Y_Cont;
        frame_n     = FRAME_Cont;
        line_end_n  = 1'b0;
        last_len_n  = LAST_LINE_LEN;
        roi_n       = 1'b0;
        x_ovf_n     = X_OVF;
        y_ovf_n     = Y_OVF;

        if (frame_start_c) begin
            frame_n = FRAME_Cont + FRAME_WIDTH'(1);
            x_ovf_n = 1'b0;
            y_ovf_n = 1'b0;
        end

        if (vs_act_c) begin
            x_n = '0;
            y_n = '0;
        end else begin
            pix_valid_n = READ_Request;
            if (READ_Request && !PIX_VALID) begin
                x_n = '0;
            end else if (READ_Request && PIX_VALID) begin
                if (X_Cont < X_MAX) begin
                    x_n = X_Cont + X_WIDTH'(1);
                end else begin
                    x_ovf_n = 1'b1;
                    x_n     = SATURATE ? X_Cont : '0;
                end
            end else if (!READ_Request && PIX_VALID) begin
                line_end_n = 1'b1;
                last_len_n = (X_WIDTH + 1)'(X_Cont) + (X_WIDTH + 1)'(1);
                x_n        = '0;
                if (Y_Cont < Y_MAX) begin
                    y_n = Y_Cont + Y_WIDTH'(1);
                end else begin
                    y_ovf_n = 1'b1;
                    y_n     = SATURATE ? Y_Cont : '0;
                end
            end
            roi_n = READ_Request
                    && in_range(32'(x_n), ROI_X0, ROI_X1)
                    && in_range(32'(y_n), ROI_Y0, ROI_Y1);
        end
    end

    // Register all tracker outputs
    always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) begin
            PIX_VALID     <= 1'b0;
            X_Cont        <= '0;
            Y_Cont        <= '0;
            FRAME_Cont    <= '0;
            LINE_END      <= 1'b0;
            LAST_LINE_LEN <= '0;
            ROI_VALID     <= 1'b0;
            X_OVF         <= 1'b0;
            Y_OVF         <= 1'b0;
        end else begin
            PIX_VALID     <= pix_valid_n;
            X_Cont        <= x_n;
            Y_Cont        <= y_n;
            FRAME_Cont    <= frame_n;
            LINE_END      <= line_end_n;
            LAST_LINE_LEN <= last_len_n;
            ROI_VALID     <= roi_n;
            X_OVF         <= x_ovf_n;
            Y_OVF         <= y_ovf_n;
        end
    end

endmodule

// File: tb/tb_vga_rd_coord_tracker.sv
// Randomised bench: default tracker plus a small wrapping/ROI/active-high-VS variant, both against a count-based model.
module tb_vga_rd_coord_tracker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic vs0 = 1'b1;
    logic vs1 = 1'b0;
    logic rr  = 1'b0;

    always #5 clk = ~clk;

    logic        pv0, le0, fs0, roi0, xo0, yo0;
    logic [10:0] x0, y0;
    logic [7:0]  fc0;
    logic [11:0] len0;
    logic        pv1, le1, fs1, roi1, xo1, yo1;
    logic [10:0] x1, y1;
    logic [7:0]  fc1;
    logic [11:0] len1;

    vga_rd_coord_tracker dut0 (
        .VGA_CLK(clk), .RESET(rst), .VGA_VS(vs0), .READ_Request(rr),
        .PIX_VALID(pv0), .X_Cont(x0), .Y_Cont(y0), .FRAME_Cont(fc0),
        .LINE_END(le0), .LAST_LINE_LEN(len0), .FRAME_START(fs0),
        .ROI_VALID(roi0), .X_OVF(xo0), .Y_OVF(yo0)
    );

    vga_rd_coord_tracker #(
        .H_ACTIVE(16), .V_ACTIVE(4), .VS_ACTIVE_LOW(1'b0), .SATURATE(1'b0),
        .ROI_X0(10), .ROI_X1(12), .ROI_Y0(1), .ROI_Y1(1)
    ) dut1 (
        .VGA_CLK(clk), .RESET(rst), .VGA_VS(vs1), .READ_Request(rr),
        .PIX_VALID(pv1), .X_Cont(x1), .Y_Cont(y1), .FRAME_Cont(fc1),
        .LINE_END(le1), .LAST_LINE_LEN(len1), .FRAME_START(fs1),
        .ROI_VALID(roi1), .X_OVF(xo1), .Y_OVF(yo1)
    );

    // Per-instance configuration
    int h_p[2]   = '{640, 16};
    int v_p[2]   = '{480, 4};
    bit sat_p[2] = '{1'b1, 1'b0};
    int rx0[2]   = '{0, 10};
    int rx1[2]   = '{639, 12};
    int ry0[2]   = '{0, 1};
    int ry1[2]   = '{479, 1};

    // Model state: pixel index within line, lines completed this frame, expected outputs
    int m_k[2], m_lines[2], m_x[2], m_y[2], m_frame[2], m_len[2];
    bit m_pv[2], m_le[2], m_fs[2], m_roi[2], m_xo[2], m_yo[2], m_vsd[2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_k[i] = 0; m_lines[i] = 0; m_x[i] = 0; m_y[i] = 0; m_frame[i] = 0; m_len[i] = 0;
            m_pv[i] = 0; m_le[i] = 0; m_fs[i] = 0; m_roi[i] = 0; m_xo[i] = 0; m_yo[i] = 0;
            m_vsd[i] = 0;
        end
    endfunction

    function automatic int coord(input int n, input int lim, input bit sat);
        if (sat) return (n < lim) ? n : lim - 1;
        return n % lim;
    endfunction

    // One clock edge of the reference behaviour for instance i
    function automatic void model_step(input int i, input bit vs_a, input bit r);
        m_fs[i]  = vs_a && !m_vsd[i];
        m_vsd[i] = vs_a;
        if (m_fs[i]) begin
            m_frame[i] = (m_frame[i] + 1) % 256;
            m_xo[i] = 0;
            m_yo[i] = 0;
        end
        m_le[i]  = 0;
        m_roi[i] = 0;
        if (vs_a) begin
            m_x[i] = 0; m_y[i] = 0; m_lines[i] = 0; m_pv[i] = 0;
        end else begin
            if (r) begin
                m_k[i] = m_pv[i] ? m_k[i] + 1 : 0;
                if (m_k[i] >= h_p[i]) m_xo[i] = 1;
                m_x[i] = coord(m_k[i], h_p[i], sat_p[i]);
                m_roi[i] = (m_x[i] >= rx0[i]) && (m_x[i] <= rx1[i])
                        && (m_y[i] >= ry0[i]) && (m_y[i] <= ry1[i]);
            end else if (m_pv[i]) begin
                m_le[i]  = 1;
                m_len[i] = m_x[i] + 1;
                m_lines[i]++;
                if (m_lines[i] >= v_p[i]) m_yo[i] = 1;
                m_y[i] = coord(m_lines[i], v_p[i], sat_p[i]);
                m_x[i] = 0;
            end
            m_pv[i] = r;
        end
    endfunction

    task automatic compare(input int i, input logic pv, input logic [10:0] x, input logic [10:0] y,
                           input logic [7:0] fc, input logic le, input logic [11:0] len,
                           input logic fs, input logic roi, input logic xo, input logic yo);
        string p;
        p = $sformatf("dut%0d_", i);
        check({p, "pix_valid"},   32'(pv),  32'(m_pv[i]));
        check({p, "x"},           32'(x),   m_x[i]);
        check({p, "y"},           32'(y),   m_y[i]);
        check({p, "frame"},       32'(fc),  m_frame[i]);
        check({p, "line_end"},    32'(le),  32'(m_le[i]));
        check({p, "last_len"},    32'(len), m_len[i]);
        check({p, "frame_start"}, 32'(fs),  32'(m_fs[i]));
        check({p, "roi_valid"},   32'(roi), 32'(m_roi[i]));
        check({p, "x_ovf"},       32'(xo),  32'(m_xo[i]));
        check({p, "y_ovf"},       32'(yo),  32'(m_yo[i]));
    endtask

    task automatic compare_all();
        compare(0, pv0, x0, y0, fc0, le0, len0, fs0, roi0, xo0, yo0);
        compare(1, pv1, x1, y1, fc1, le1, len1, fs1, roi1, xo1, yo1);
    endtask

    // Drive logical VS level and read request for one edge, then check
    task automatic drive(input bit vs_a, input bit r);
        vs0 = ~vs_a;
        vs1 = vs_a;
        rr  = r;
        @(posedge clk);
        model_step(0, vs_a, r);
        model_step(1, vs_a, r);
        #1;
        compare_all();
    endtask

    task automatic line(input int n, input int gap);
        repeat (n) drive(1'b0, 1'b1);
        repeat (gap) drive(1'b0, 1'b0);
    endtask

    task automatic vs_pulse(input int n);
        repeat (n) drive(1'b1, 1'b0);
    endtask

    task automatic reset_now();
        rst = 1'b1;
        #2;
        model_reset();
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset with VS active on both instances
        rst = 1'b1; vs0 = 1'b0; vs1 = 1'b1; rr = 1'b0;
        #12;
        compare_all();
        rst = 1'b0;
        vs_pulse(3);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);

        // Three full lines, then an over-long line, then a new frame
        repeat (3) line(640, 10);
        line(645, 3);
        vs_pulse(2);
        drive(1'b0, 1'b0);

        // Short lines with single idle gaps: Y wrap and ROI on the small instance
        repeat (5) line(20, 1);

        // VS asserted mid-line with request still high
        repeat (101) drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);

        // Asynchronous reset in the middle of a line
        repeat (50) drive(1'b0, 1'b1);
        reset_now();
        line(5, 2);

        // Randomised frames
        for (int f = 0; f < 12; f++) begin
            int nl;
            vs_pulse(int'($urandom_range(1, 3)));
            repeat (int'($urandom_range(1, 4))) drive(1'b0, 1'b0);
            nl = int'($urandom_range(1, 6));
            for (int l = 0; l < nl; l++) begin
                int len;
                len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(636, 646))
                                                  : int'($urandom_range(1, 20));
                if ($urandom_range(0, 9) == 0) begin
                    repeat (len) drive(1'b0, 1'b1);
                    drive(1'b1, 1'b1);
                end else begin
                    line(len, int'($urandom_range(1, 10)));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_rd_coord_tracker.md
Name: vga_rd_coord_tracker

Overview:
Parametrised successor of the VGA read-side pixel coordinate counter. It tracks the X/Y coordinates of pixels read from the frame buffer, counts frames, and emits line-end and frame-start pulses. It also flags region-of-interest (ROI) membership and sticky X/Y overflow errors. It sits between the VGA timing/read-request logic and the downstream vision pipeline, which consumes the coordinates aligned with PIX_VALID.

Parameters:
X_WIDTH, 11, width of X_Cont
Y_WIDTH, 11, width of Y_Cont
FRAME_WIDTH, 8, width of FRAME_Cont (wraps)
H_ACTIVE, 640, max pixels per line; legal X is 0..H_ACTIVE-1
V_ACTIVE, 480, max lines per frame; legal Y is 0..V_ACTIVE-1
VS_ACTIVE_LOW, 1, 1 = VGA_VS active-low, 0 = active-high
SATURATE, 1, 1 = clamp on overflow, 0 = wrap to 0
ROI_X0, 0 / ROI_X1, 639 / ROI_Y0, 0 / ROI_Y1, 479, inclusive ROI bounds

Ports:
VGA_CLK  in  1  pixel clock; all logic on its rising edge
RESET  in  1  asynchronous, active-high reset
VGA_VS  in  1  vertical sync, synchronous to VGA_CLK, polarity per VS_ACTIVE_LOW
READ_Request  in  1  pixel read valid; one pixel per high cycle
PIX_VALID  out  1  registered READ_Request, aligned with X_Cont/Y_Cont
X_Cont  out  X_WIDTH  column of current pixel
Y_Cont  out  Y_WIDTH  row of current pixel
FRAME_Cont  out  FRAME_WIDTH  frames seen since reset
LINE_END  out  1  one-cycle pulse after the last pixel of a line
LAST_LINE_LEN  out  X_WIDTH+1  pixel count of the most recent completed line
FRAME_START  out  1  one-cycle pulse on VS assertion
ROI_VALID  out  1  PIX_VALID and (X,Y) inside the ROI
X_OVF  out  1  sticky: a line exceeded H_ACTIVE pixels
Y_OVF  out  1  sticky: a frame exceeded V_ACTIVE lines

Behaviour:
- Reset: every output and internal register is 0, including the VS delay register vs_d. A VS that is active at the first edge after reset therefore produces FRAME_START and FRAME_Cont=1.
- vs_act = VS_ACTIVE_LOW ? !VGA_VS : VGA_VS. vs_d <= vs_act on every edge.
- Frame start (vs_act & !vs_d), on that edge:
  - FRAME_START <= 1
  - FRAME_Cont <= FRAME_Cont+1, wrapping
  - X_OVF <= 0, Y_OVF <= 0
- While vs_act is high:
  - X_Cont, Y_Cont <= 0
  - PIX_VALID, ROI_VALID, LINE_END <= 0
  - READ_Request is ignored; VS wins over any simultaneous pixel or line end.
- Otherwise, per edge (p = current PIX_VALID, r = READ_Request):
  - PIX_VALID <= r
  - r & !p (first pixel of line): X_Cont <= 0
  - r & p: if X_Cont < H_ACTIVE-1, X_Cont <= X_Cont+1; else X_OVF <= 1 and X_Cont <= (SATURATE ? X_Cont : 0)
  - !r & p (line end):
    - LINE_END <= 1
    - LAST_LINE_LEN <= X_Cont+1
    - X_Cont <= 0
    - if Y_Cont < V_ACTIVE-1, Y_Cont <= Y_Cont+1; else Y_OVF <= 1 and Y_Cont <= (SATURATE ? Y_Cont : 0)
  - !r & !p: all counters hold.
- Pulses: LINE_END and FRAME_START are high for exactly one cycle per event.
- Latency: READ_Request to PIX_VALID/X/Y/ROI_VALID is 1 cycle. The first line is Y=0; Y advances only after a line completes.
- ROI_VALID is registered from the next-state X/Y and r, so it stays aligned with PIX_VALID. Bounds are inclusive.
- Widths: H_ACTIVE <= 2^X_WIDTH and V_ACTIVE <= 2^Y_WIDTH, checked by elaboration assertion. The X+1 for LAST_LINE_LEN is computed at X_WIDTH+1 bits.
- Reset mid-line: all state clears immediately and the next pixel starts at X=0, Y=0.
- Back-to-back lines with a single idle cycle are legal.

Decomposition:
- Package vga_rd_pkg: default widths, H_ACTIVE/V_ACTIVE defaults, and a coordinate struct typedef {x, y, valid}.
- Sub-module vga_vs_edge: VS polarity normaliser plus registered rising-edge detector, producing vs_act and frame_start.

Test Plan:
- Reset, then VS pulse, then 3 lines of 640 valid cycles with 10 idle cycles between lines -> FRAME_Cont=1; X runs 0..639 per line; Y=0,1,2; three LINE_END pulses; LAST_LINE_LEN=640.
- SATURATE=1: a line of 645 valid cycles -> X holds at 639 for 6 cycles; X_OVF=1 and stays set until the next FRAME_START clears it.
- SATURATE=0, V_ACTIVE=4: 5 lines -> Y sequence 0,1,2,3,0; Y_OVF=1.
- VS asserted mid-line at X=100 with READ_Request still high -> the next cycle shows X=0, Y=0, PIX_VALID=0; no LINE_END; FRAME_START=1; FRAME_Cont increments.
- ROI set to X 10..12, Y 1..1; two lines of 20 pixels -> ROI_VALID high for exactly 3 cycles, at X=10,11,12 on Y=1.
- VS_ACTIVE_LOW=0 with VS held high across reset release -> FRAME_START at the first edge; FRAME_Cont=1; no second pulse until VS drops and rises again.
